// File: rtl/gsim_result_drain.sv
// Result drain for the GSIM accelerator: 16 solution words in, streamed out in index order.
// Optional macro GSIM_DRAIN_SAT_EN selects saturating (vs wrapping) output conversion.
module gsim_result_drain #(
   parameter int BIT_WIDTH = 32,
   parameter int FRAC_BITS = 16,
   parameter int OUT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wr_en_i,
   input  logic [3:0]           wr_idx_i,
   input  logic [BIT_WIDTH-1:0] wr_data_i,
   input  logic                 done_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [OUT_WIDTH-1:0] out_data_o,
   output logic [3:0]           out_idx_o,
   output logic                 busy_o,
   output logic                 drain_done_o,
   output logic                 wr_err_o
);

   // state    | meaning
   // ST_IDLE  | accepting writes, waiting for done
   // ST_DRAIN | streaming slot[ptr] out, writes rejected
   typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

   state_t               state_q, state_d;
   logic [3:0]           ptr_q, ptr_d;
   logic [BIT_WIDTH-1:0] slots_q [16];
   logic [BIT_WIDTH-1:0] slots_d [16];
   logic                 drain_done_q, drain_done_d;
   logic                 wr_err_q, wr_err_d;

`ifdef GSIM_DRAIN_SAT_EN
   localparam logic signed [BIT_WIDTH-1:0] SAT_MAX =
      {{(BIT_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [BIT_WIDTH-1:0] SAT_MIN =
      {{(BIT_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`endif

   function automatic logic [OUT_WIDTH-1:0] conv(input logic [BIT_WIDTH-1:0] w);
      logic signed [BIT_WIDTH-1:0] sh;
      sh = $signed(w) >>> FRAC_BITS;
`ifdef GSIM_DRAIN_SAT_EN
      if (sh > SAT_MAX)
         conv = OUT_WIDTH'(SAT_MAX);
      else if (sh < SAT_MIN)
         conv = OUT_WIDTH'(SAT_MIN);
      else
         conv = OUT_WIDTH'(sh);
`else
      conv = OUT_WIDTH'(sh);
`endif
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         drain_done_q <= 1'b0;
         wr_err_q     <= 1'b0;
         for (int i = 0; i < 16; i++) slots_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         drain_done_q <= drain_done_d;
         wr_err_q     <= wr_err_d;
         for (int i = 0; i < 16; i++) slots_q[i] <= slots_d[i];
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      drain_done_d = 1'b0;
      wr_err_d     = wr_err_q;
      for (int i = 0; i < 16; i++) slots_d[i] = slots_q[i];
      case (state_q)
         ST_IDLE: begin
            if (wr_en_i) slots_d[wr_idx_i] = wr_data_i;
            if (done_i) begin
               state_d  = ST_DRAIN;
               ptr_d    = '0;
               wr_err_d = 1'b0;
            end
         end
         ST_DRAIN: begin
            if (wr_en_i) wr_err_d = 1'b1;
            if (out_ready_i) begin
               ptr_d = ptr_q + 4'd1;
               // Last beat: storage is wiped so the next problem starts from zero.
               if (ptr_q == 4'd15) begin
                  state_d      = ST_IDLE;
                  drain_done_d = 1'b1;
                  for (int i = 0; i < 16; i++) slots_d[i] = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign out_valid_o  = (state_q == ST_DRAIN);
   assign busy_o       = (state_q == ST_DRAIN);
   assign out_idx_o    = out_valid_o ? ptr_q : 4'd0;
   assign out_data_o   = out_valid_o ? conv(slots_q[ptr_q]) : '0;
   assign drain_done_o = drain_done_q;
   assign wr_err_o     = wr_err_q;

endmodule

// File: tb/tb_gsim_result_drain.sv
// Scoreboard bench for gsim_result_drain: expected beats queued at done, monitor pops on transfers.
module tb_gsim_result_drain;
   localparam int BW = 32;
   localparam int FB = 16;
   localparam int OW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [3:0]    wr_idx;
   logic [BW-1:0] wr_data;
   logic          done;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;
   logic [3:0]    out_idx;
   logic          busy;
   logic          drain_done;
   logic          wr_err;

   gsim_result_drain #(.BIT_WIDTH(BW), .FRAC_BITS(FB), .OUT_WIDTH(OW)) dut (
      .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
      .done_i(done), .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .out_idx_o(out_idx), .busy_o(busy), .drain_done_o(drain_done), .wr_err_o(wr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]    idx;
      logic [OW-1:0] data;
   } beat_t;

   int            n_cmp = 0;
   int            n_err = 0;
   beat_t         exp_q[$];
   logic [BW-1:0] model_mem [16];
   bit            draining = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Fixed-point value floor(w / 2^FB), then saturate or wrap into OW bits.
   function automatic logic [OW-1:0] ref_conv(input logic [BW-1:0] w);
      longint v;
      v = longint'($signed(w)) >>> FB;
`ifdef GSIM_DRAIN_SAT_EN
      if (v > (longint'(1) <<< (OW-1)) - 1) v = (longint'(1) <<< (OW-1)) - 1;
      if (v < -(longint'(1) <<< (OW-1))) v = -(longint'(1) <<< (OW-1));
`endif
      return OW'(v);
   endfunction

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(out_idx), 64'hdead);
         end else begin
            check("beat_idx", 64'(out_idx), 64'(exp_q[0].idx));
            check("beat_data", 64'(out_data), 64'(exp_q[0].data));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [3:0] idx, input logic [BW-1:0] data);
      wr_en = 1'b1; wr_idx = idx; wr_data = data;
      tick();
      wr_en = 1'b0;
      if (!draining) model_mem[idx] = data;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
   endtask

   task automatic start_drain(input bit with_wr, input logic [3:0] idx, input logic [BW-1:0] data);
      beat_t b;
      done = 1'b1;
      if (with_wr) begin
         wr_en = 1'b1; wr_idx = idx; wr_data = data;
         model_mem[idx] = data;
      end
      tick();
      done = 1'b0; wr_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         b.idx  = 4'(i);
         b.data = ref_conv(model_mem[i]);
         exp_q.push_back(b);
      end
      clear_model();
      draining = 1;
      check("valid_after_done", 64'(out_valid), 64'd1);
      check("busy_after_done", 64'(busy), 64'd1);
   endtask

   // mode 0: ready held high; 1: pattern 1,0,0,1; 2: random
   task automatic run_drain(input int mode, input bit check_lat);
      int  cyc;
      bit  seen;
      seen = 0;
      cyc  = 0;
      while (!seen && cyc < 300) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         tick();
         cyc++;
         if (drain_done) seen = 1;
      end
      out_ready = 1'b0;
      draining = 0;
      check("drain_done_seen", 64'(seen), 64'd1);
      if (seen) begin
         check("valid_at_drain_done", 64'(out_valid), 64'd0);
         check("busy_at_drain_done", 64'(busy), 64'd0);
         if (check_lat) check("drain_latency", 64'(cyc), 64'd16);
         tick();
         check("drain_done_one_cycle", 64'(drain_done), 64'd0);
      end
      check("beats_left", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0; done = 1'b0; out_ready = 1'b0;
      clear_model();
      tick();
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_data", 64'(out_data), 64'd0);
      check("rst_idx", 64'(out_idx), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_drain_done", 64'(drain_done), 64'd0);
      check("rst_wr_err", 64'(wr_err), 64'd0);
      rst = 1'b0;
      tick();

      // Ramp: slot i = i.0 in fixed point, full-rate drain
      for (int i = 0; i < 16; i++) do_write(4'(i), BW'(i) << FB);
      start_drain(0, '0, '0);
      run_drain(0, 1);

      // Stalled drain with the same ramp, plus a double write to one slot
      for (int i = 0; i < 16; i++) do_write(4'(i), BW'(i) << FB);
      do_write(4'd4, 32'h0009_8000);
      start_drain(0, '0, '0);
      run_drain(1, 0);

      // Write coincident with done is included; next drain is all zeros
      start_drain(1, 4'd3, 32'h0005_0000);
      run_drain(0, 1);
      start_drain(0, '0, '0);
      run_drain(0, 1);

      // Writes during drain are dropped and flag wr_err until the next done
      do_write(4'd1, 32'h0001_0000);
      start_drain(0, '0, '0);
      do_write(4'd2, 32'h0033_0000);
      check("wr_err_set", 64'(wr_err), 64'd1);
      run_drain(0, 0);
      check("wr_err_sticky", 64'(wr_err), 64'd1);
      start_drain(0, '0, '0);
      check("wr_err_cleared", 64'(wr_err), 64'd0);
      run_drain(2, 0);

      // Conversion extremes
      do_write(4'd7, 32'h7FFF_0000);
      do_write(4'd8, 32'h8000_0000);
      do_write(4'd9, 32'hFFFF_FFFF);
      do_write(4'd10, 32'h0000_FFFF);
      start_drain(0, '0, '0);
      run_drain(0, 1);

      // Reset while beat 5 is presented
      for (int i = 0; i < 16; i++) do_write(4'(i), 32'h0002_0000 + BW'(i));
      start_drain(0, '0, '0);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      out_ready = 1'b0;
      check("idx_before_rst", 64'(out_idx), 64'd5);
      rst = 1'b1;
      #1;
      check("rst_mid_valid", 64'(out_valid), 64'd0);
      check("rst_mid_busy", 64'(busy), 64'd0);
      exp_q.delete();
      clear_model();
      draining = 0;
      tick();
      rst = 1'b0;
      tick();
      start_drain(0, '0, '0);
      run_drain(0, 1);

      // Randomized problems
      for (int t = 0; t < 12; t++) begin
         int nw;
         nw = $urandom_range(0, 20);
         for (int k = 0; k < nw; k++) begin
            logic [BW-1:0] d;
            d = $urandom;
            do_write(4'($urandom_range(0, 15)), d);
         end
         if ($urandom_range(0, 1) == 1)
            start_drain(1, 4'($urandom_range(0, 15)), BW'($urandom));
         else
            start_drain(0, '0, '0);
         run_drain($urandom_range(0, 2), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, %0d compared", n_cmp);
      $fatal(1, "timeout");
   end
endmodule
